pkg_wr_ctrl: RTL and testbench
==============================

PKG_WR_CTRL -- requirements
Module: pkg_wr_ctrl

Interface
REQ-001 Parameters: RAM_DEPTH, default 1144, words per priority RAM; ADDR_WIDTH, default 11, RAM address width.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_vld  input  1  input beat valid; no back-pressure, every valid beat is consumed.
REQ-005 in_sop / in_eop  input  1 each  header beat / last data beat markers, sampled with in_vld.
REQ-006 in_qos  input  1  priority on the sop beat: 1 = high RAM, 0 = low RAM.
REQ-007 in_dest  input  3  destination channel id on the sop beat.
REQ-008 in_data  input  8  payload byte on data beats; ignored on the sop beat.
REQ-009 hram_wen / lram_wen  output  1 each  RAM write enables.
REQ-010 hram_waddr / lram_waddr  output  11 each  RAM write addresses.
REQ-011 hram_wdata / lram_wdata  output  11 each  RAM write words.
REQ-012 hram_raddr / lram_raddr  input  11 each  reader's current read pointers.
REQ-013 high_real_waddr / low_real_waddr  output  11 each  committed write pointers: next free location after the last complete packet.
REQ-014 drop_pulse  output  1  one-cycle pulse per dropped packet.

Function
REQ-015 Packet format: one sop beat (header, in_sop=1, no data), then 1..N data beats; eop is on the last data beat. A sop beat with in_eop=1 is illegal and is dropped.
REQ-016 Header word = {in_dest, 8'h00}. Data word = {2'b00, in_eop, in_data}.
REQ-017 High RAM fills in descending order: after 0 the next address is RAM_DEPTH-1. Low RAM fills in ascending order: after RAM_DEPTH-1 the next address is 0.
REQ-018 Each RAM has a working pointer wptr_h/wptr_l that advances on every word written.
REQ-019 The committed pointer is loaded from the working pointer value after the eop word, so the reader never sees a partial packet.
REQ-020 Used words, per RAM, modulo RAM_DEPTH: high used = (hram_raddr - wptr_h); low used = (wptr_l - lram_raddr).
REQ-021 A RAM is full when used = RAM_DEPTH-1; one slot always stays empty so that full and empty are distinguishable.
REQ-022 Write ports are registered: a beat accepted in cycle N drives wen/waddr/wdata in cycle N+1. At most one RAM is written per cycle; the other RAM's wen is 0.
REQ-023 The committed pointer is updated in cycle N+1 for an eop beat accepted in cycle N.
REQ-024 State machine states: IDLE, WRITE, DROP. The packet's qos is latched on sop and selects the RAM for the whole packet.
REQ-025 IDLE, in_vld & in_sop, target RAM not full: write header, go to WRITE.
REQ-026 IDLE, in_vld & in_sop, target RAM full, or sop with in_eop=1: pulse drop_pulse, go to DROP (or stay in IDLE if in_eop=1).
REQ-027 IDLE, in_vld without sop: beat is discarded silently and the state stays IDLE.
REQ-028 WRITE, data beat, RAM not full: write the word; on in_eop, commit and go to IDLE.
REQ-029 WRITE, data beat, RAM full: no write, working pointer rolls back to the committed pointer, drop_pulse, go to DROP (to IDLE if the beat has in_eop).
REQ-030 WRITE, new in_sop (missing eop): roll back the current packet, pulse drop_pulse, and process the sop as in IDLE in the same cycle.
REQ-031 DROP: discard beats until in_eop, then go to IDLE; a sop in DROP is processed as in IDLE.
REQ-032 Committed pointers only move forward by whole packets; a rollback never changes the committed pointer.

Reset
REQ-033 On rst_n low, asynchronously: state=IDLE; wptr_h=high_real_waddr=RAM_DEPTH-1; wptr_l=low_real_waddr=0; all wen, waddr, wdata and drop_pulse are 0.
REQ-034 A packet in flight at reset is lost; after release the block waits for a fresh sop.

Verification
REQ-035 Low packet sop (dest=5) plus 3 bytes A1,A2,A3 (eop on A3): lram writes addr0=0x500, addr1=0x0A1, addr2=0x0A2, addr3=0x1A3; low_real_waddr goes 0->4 one cycle after the eop beat.
REQ-036 High packet sop plus 2 bytes from reset: hram addresses 1143, 1142, 1141; high_real_waddr = 1140 after eop.
REQ-037 Wrap: lram_raddr=1140 and wptr_l=1142, 4-word packet: addresses 1142, 1143, 0, 1; low_real_waddr = 2.
REQ-038 Overflow mid-packet: low used = 1141, 4-word packet: 2 words written, drop_pulse asserted once, low_real_waddr unchanged, next packet starts at the old committed address.
REQ-039 sop in WRITE without eop: one drop_pulse, the new packet header is written at the rolled-back address.
REQ-040 Reset asserted mid-packet: all outputs return to REQ-033 values; data beats before the next sop cause no writes.

Source files
------------

// File: rtl/pkg_wr_ctrl_if.sv
// pkg_wr_ctrl_if: packet input beats plus high/low priority RAM write and pointer signals
interface pkg_wr_ctrl_if #(parameter int ADDR_WIDTH = 11);
  logic                  in_vld;
  logic                  in_sop;
  logic                  in_eop;
  logic                  in_qos;
  logic [2:0]            in_dest;
  logic [7:0]            in_data;
  logic                  hram_wen;
  logic                  lram_wen;
  logic [ADDR_WIDTH-1:0] hram_waddr;
  logic [ADDR_WIDTH-1:0] lram_waddr;
  logic [10:0]           hram_wdata;
  logic [10:0]           lram_wdata;
  logic [ADDR_WIDTH-1:0] hram_raddr;
  logic [ADDR_WIDTH-1:0] lram_raddr;
  logic [ADDR_WIDTH-1:0] high_real_waddr;
  logic [ADDR_WIDTH-1:0] low_real_waddr;
  logic                  drop_pulse;
  modport master (
    output in_vld, in_sop, in_eop, in_qos, in_dest, in_data, hram_raddr, lram_raddr,
    input  hram_wen, lram_wen, hram_waddr, lram_waddr, hram_wdata, lram_wdata,
           high_real_waddr, low_real_waddr, drop_pulse
  );
  modport slave (
    input  in_vld, in_sop, in_eop, in_qos, in_dest, in_data, hram_raddr, lram_raddr,
    output hram_wen, lram_wen, hram_waddr, lram_waddr, hram_wdata, lram_wdata,
           high_real_waddr, low_real_waddr, drop_pulse
  );
endinterface

// File: rtl/pkg_wr_ctrl.sv
// pkg_wr_ctrl: writes packets into high (descending) or low (ascending) priority RAM,
// committing the read-visible pointer only on complete packets and dropping on overflow.
module pkg_wr_ctrl #(
  parameter int RAM_DEPTH  = 1144,
  parameter int ADDR_WIDTH = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  pkg_wr_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;
  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(RAM_DEPTH-1);
  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);
  state_t                state, state_n;
  logic                  qos_q, qos_n;
  logic [ADDR_WIDTH-1:0] wptr_h, wptr_l, base_h, base_l, nxt_h, nxt_l;
  logic                  full_h, full_l, rb_sop, rb, wr, wsel, commit, drop;
  logic [10:0]           word;
  function automatic logic is_full(input logic [ADDR_WIDTH-1:0] a, input logic [ADDR_WIDTH-1:0] b);
    logic [ADDR_WIDTH:0] used;
    used = (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + DEPTH - {1'b0, b};
    return used == DEPTH - 1'b1;
  endfunction
  // A sop arriving mid-packet rolls the old packet back before the new header is placed
  assign rb_sop = bus.in_vld & bus.in_sop & (state == WRITE);
  assign base_h = (rb_sop & qos_q) ? bus.high_real_waddr : wptr_h;
  assign base_l = (rb_sop & ~qos_q) ? bus.low_real_waddr : wptr_l;
  assign nxt_h  = (base_h == '0) ? LAST : base_h - ONE;
  assign nxt_l  = (base_l == LAST) ? '0 : base_l + ONE;
  assign full_h = is_full(bus.hram_raddr, base_h);
  assign full_l = is_full(base_l, bus.lram_raddr);
  always_comb begin
    state_n = state;
    qos_n   = qos_q;
    wsel    = bus.in_sop ? bus.in_qos : qos_q;
    wr      = 1'b0;
    rb      = rb_sop;
    commit  = 1'b0;
    drop    = rb_sop;
    word    = bus.in_sop ? {bus.in_dest, 8'h00} : {2'b00, bus.in_eop, bus.in_data};
    if (bus.in_vld) begin
      if (bus.in_sop) begin
        qos_n = bus.in_qos;
        if (bus.in_eop || (bus.in_qos ? full_h : full_l)) begin
          drop    = 1'b1;
          state_n = bus.in_eop ? IDLE : DROP;
        end else begin
          wr      = 1'b1;
          state_n = WRITE;
        end
      end else if (state == WRITE) begin
        if (qos_q ? full_h : full_l) begin
          rb      = 1'b1;
          drop    = 1'b1;
          state_n = bus.in_eop ? IDLE : DROP;
        end else begin
          wr      = 1'b1;
          commit  = bus.in_eop;
          state_n = bus.in_eop ? IDLE : WRITE;
        end
      end else if (state == DROP && bus.in_eop) begin
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      qos_q               <= 1'b0;
      wptr_h              <= LAST;
      wptr_l              <= '0;
      bus.high_real_waddr <= LAST;
      bus.low_real_waddr  <= '0;
      bus.hram_wen        <= 1'b0;
      bus.lram_wen        <= 1'b0;
      bus.hram_waddr      <= '0;
      bus.lram_waddr      <= '0;
      bus.hram_wdata      <= '0;
      bus.lram_wdata      <= '0;
      bus.drop_pulse      <= 1'b0;
    end else begin
      state               <= state_n;
      qos_q               <= qos_n;
      wptr_h              <= (wr & wsel) ? nxt_h : (rb & qos_q) ? bus.high_real_waddr : wptr_h;
      wptr_l              <= (wr & ~wsel) ? nxt_l : (rb & ~qos_q) ? bus.low_real_waddr : wptr_l;
      bus.high_real_waddr <= (commit & wsel) ? nxt_h : bus.high_real_waddr;
      bus.low_real_waddr  <= (commit & ~wsel) ? nxt_l : bus.low_real_waddr;
      bus.hram_wen        <= wr & wsel;
      bus.lram_wen        <= wr & ~wsel;
      bus.hram_waddr      <= (wr & wsel) ? base_h : bus.hram_waddr;
      bus.lram_waddr      <= (wr & ~wsel) ? base_l : bus.lram_waddr;
      bus.hram_wdata      <= (wr & wsel) ? word : bus.hram_wdata;
      bus.lram_wdata      <= (wr & ~wsel) ? word : bus.lram_wdata;
      bus.drop_pulse      <= drop;
    end
  end
endmodule

// File: tb/tb_pkg_wr_ctrl.sv
// tb_pkg_wr_ctrl: directed packets with a scoreboard of expected RAM writes and drop pulses
module tb_pkg_wr_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  typedef struct {int kind; int addr; int data;} ev_t;
  ev_t  q[$];
  pkg_wr_ctrl_if #(.ADDR_WIDTH(11)) bus();
  pkg_wr_ctrl #(.RAM_DEPTH(1144), .ADDR_WIDTH(11)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask
  task automatic push(input int k, input int a, input int d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    q.push_back(e);
  endtask
  task automatic pop_cmp(input int k, input int a, input int d);
    ev_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected event: kind %0d addr %0d data 0x%0h, expected none", k, a, d);
    end else begin
      e = q.pop_front();
      chk("event kind", k, e.kind);
      if (k != 2) begin
        chk("waddr", a, e.addr);
        chk("wdata", d, e.data);
      end
    end
  endtask
  // kinds: 0 low write, 1 high write, 2 drop pulse
  always @(negedge clk) if (rst_n) begin
    if (bus.drop_pulse) pop_cmp(2, 0, 0);
    if (bus.hram_wen) pop_cmp(1, int'(bus.hram_waddr), int'(bus.hram_wdata));
    if (bus.lram_wen) pop_cmp(0, int'(bus.lram_waddr), int'(bus.lram_wdata));
  end
  task automatic beat(input logic sop, input logic eop, input logic qos, input logic [2:0] dest, input logic [7:0] data);
    bus.in_vld = 1'b1; bus.in_sop = sop; bus.in_eop = eop;
    bus.in_qos = qos; bus.in_dest = dest; bus.in_data = data;
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
  endtask
  task automatic chk_reset();
    chk("rst hram_wen", int'(bus.hram_wen), 0);
    chk("rst lram_wen", int'(bus.lram_wen), 0);
    chk("rst hram_waddr", int'(bus.hram_waddr), 0);
    chk("rst lram_waddr", int'(bus.lram_waddr), 0);
    chk("rst hram_wdata", int'(bus.hram_wdata), 0);
    chk("rst lram_wdata", int'(bus.lram_wdata), 0);
    chk("rst high_real", int'(bus.high_real_waddr), 1143);
    chk("rst low_real", int'(bus.low_real_waddr), 0);
    chk("rst drop", int'(bus.drop_pulse), 0);
  endtask
  initial begin
    logic eop;
    bus.in_vld = 0; bus.in_sop = 0; bus.in_eop = 0; bus.in_qos = 0;
    bus.in_dest = 0; bus.in_data = 0;
    bus.hram_raddr = 11'd1143; bus.lram_raddr = 11'd0;
    repeat (3) @(posedge clk);
    #1 chk_reset();
    @(negedge clk) rst_n = 1'b1;
    // low packet, dest 5
    push(0, 0, 'h500); beat(1, 0, 0, 3'd5, 8'h00);
    push(0, 1, 'h0A1); beat(0, 0, 0, 3'd0, 8'hA1);
    push(0, 2, 'h0A2); beat(0, 0, 0, 3'd0, 8'hA2);
    chk("low_real before eop", int'(bus.low_real_waddr), 0);
    push(0, 3, 'h1A3); beat(0, 1, 0, 3'd0, 8'hA3);
    chk("low_real after eop", int'(bus.low_real_waddr), 4);
    // high packet, descending from 1143
    push(1, 1143, 'h200); beat(1, 0, 1, 3'd2, 8'h00);
    push(1, 1142, 'h0B1); beat(0, 0, 1, 3'd0, 8'hB1);
    chk("high_real before eop", int'(bus.high_real_waddr), 1143);
    push(1, 1141, 'h1B2); beat(0, 1, 1, 3'd0, 8'hB2);
    chk("high_real after eop", int'(bus.high_real_waddr), 1140);
    // long low packet to bring the pointer to 1142
    bus.lram_raddr = 11'd4;
    push(0, 4, 'h100); beat(1, 0, 0, 3'd1, 8'h00);
    for (int i = 0; i < 1137; i++) begin
      eop = (i == 1136);
      push(0, 5 + i, {eop, i[7:0]});
      beat(0, eop, 0, 3'd0, i[7:0]);
    end
    chk("low_real long", int'(bus.low_real_waddr), 1142);
    // wrap from 1143 to 0
    bus.lram_raddr = 11'd1140;
    push(0, 1142, 'h300); beat(1, 0, 0, 3'd3, 8'h00);
    push(0, 1143, 'h0C1); beat(0, 0, 0, 3'd0, 8'hC1);
    push(0, 0, 'h0C2); beat(0, 0, 0, 3'd0, 8'hC2);
    push(0, 1, 'h1C3); beat(0, 1, 0, 3'd0, 8'hC3);
    chk("low_real wrap", int'(bus.low_real_waddr), 2);
    // overflow mid-packet: used 1141
    bus.lram_raddr = 11'd5;
    push(0, 2, 'h400); beat(1, 0, 0, 3'd4, 8'h00);
    push(0, 3, 'h0D1); beat(0, 0, 0, 3'd0, 8'hD1);
    push(2, 0, 0);     beat(0, 0, 0, 3'd0, 8'hD2);
    beat(0, 1, 0, 3'd0, 8'hD3);
    chk("low_real overflow", int'(bus.low_real_waddr), 2);
    bus.lram_raddr = 11'd2;
    push(0, 2, 'h600); beat(1, 0, 0, 3'd6, 8'h00);
    push(0, 3, 'h1E1); beat(0, 1, 0, 3'd0, 8'hE1);
    chk("low_real after overflow", int'(bus.low_real_waddr), 4);
    // stray data beat in IDLE, then illegal sop with eop
    beat(0, 0, 0, 3'd0, 8'h55);
    push(2, 0, 0); beat(1, 1, 0, 3'd3, 8'h00);
    // sop in WRITE without eop
    push(0, 4, 'h700); beat(1, 0, 0, 3'd7, 8'h00);
    push(0, 5, 'h0F1); beat(0, 0, 0, 3'd0, 8'hF1);
    push(0, 6, 'h0F2); beat(0, 0, 0, 3'd0, 8'hF2);
    push(2, 0, 0); push(0, 4, 'h100); beat(1, 0, 0, 3'd1, 8'h00);
    chk("low_real no-eop", int'(bus.low_real_waddr), 4);
    push(0, 5, 'h171); beat(0, 1, 0, 3'd0, 8'h71);
    chk("low_real after resync", int'(bus.low_real_waddr), 6);
    // high RAM full on sop
    bus.hram_raddr = 11'd1139;
    push(2, 0, 0); beat(1, 0, 1, 3'd2, 8'h00);
    beat(0, 0, 1, 3'd0, 8'h11);
    beat(0, 1, 1, 3'd0, 8'h12);
    chk("high_real full sop", int'(bus.high_real_waddr), 1140);
    bus.hram_raddr = 11'd1140;
    push(1, 1140, 'h400); beat(1, 0, 1, 3'd4, 8'h00);
    push(1, 1139, 'h1AB); beat(0, 1, 1, 3'd0, 8'hAB);
    chk("high_real after full", int'(bus.high_real_waddr), 1138);
    // reset in the middle of a low packet
    push(0, 6, 'h500); beat(1, 0, 0, 3'd5, 8'h00);
    push(0, 7, 'h0C7); beat(0, 0, 0, 3'd0, 8'hC7);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset();
    bus.lram_raddr = 11'd0; bus.hram_raddr = 11'd1143;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    beat(0, 0, 0, 3'd0, 8'h33);
    beat(0, 1, 0, 3'd0, 8'h34);
    push(0, 0, 'h200); beat(1, 0, 0, 3'd2, 8'h00);
    push(0, 1, 'h1EE); beat(0, 1, 0, 3'd0, 8'hEE);
    chk("low_real after reset", int'(bus.low_real_waddr), 2);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("scoreboard left", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
